// File: rtl/binary_to_bcd_encoder.sv
// Iterative shift-add-3 converter: 8-bit ALU result plus flags -> Units/Tens/Hundreds BCD.
// Optional macro SIGNED_INPUT_EN: Binary is two's complement, magnitude converted, Negative output added.
module binary_to_bcd_encoder #(
    parameter bit HOLD_OUTPUT = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] Binary,
    input  logic       Overflow_in,
    input  logic       Carry_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] Units,
    output logic [3:0] Tens,
    output logic [1:0] Hundreds,
    output logic       Zero,
    output logic       Overflow,
    output logic       Carry_out,
`ifdef SIGNED_INPUT_EN
    output logic       Negative,
`endif
    output logic       fsm_state
);
    // Handshake: start is sampled only while busy=0; an accepted start holds busy high for
    // 8 cycles, then done pulses for one cycle as the result and flags update together.
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t     state, state_next;
    logic [2:0] count;
    logic [7:0] operand, operand_next, magnitude;
    logic [9:0] scratch, scratch_next;
    logic [3:0] adj_units, adj_tens;
    logic       ov_cap, cy_cap, last_iter;
`ifdef SIGNED_INPUT_EN
    logic       neg_cap;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SHIFT);
        fsm_state = state;
    end

    always_comb begin
`ifdef SIGNED_INPUT_EN
        magnitude = Binary[7] ? (~Binary + 8'd1) : Binary;
`else
        magnitude = Binary;
`endif
        last_iter    = (state == SHIFT) && (count == 3'd7);
        adj_units    = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
        adj_tens     = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
        // Top scratch bit falls off: Hundreds never needs more than two bits for 8-bit input.
        scratch_next = {scratch[8], adj_tens, adj_units, operand[7]};
        operand_next = {operand[6:0], 1'b0};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= 3'd0;
            operand   <= 8'd0;
            scratch   <= 10'd0;
            ov_cap    <= 1'b0;
            cy_cap    <= 1'b0;
            done      <= 1'b0;
            Units     <= 4'd0;
            Tens      <= 4'd0;
            Hundreds  <= 2'd0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            Carry_out <= 1'b0;
`ifdef SIGNED_INPUT_EN
            neg_cap   <= 1'b0;
            Negative  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        operand <= magnitude;
                        scratch <= 10'd0;
                        ov_cap  <= Overflow_in;
                        cy_cap  <= Carry_in;
                        count   <= 3'd0;
`ifdef SIGNED_INPUT_EN
                        neg_cap <= Binary[7];
`endif
                        if (!HOLD_OUTPUT) begin
                            Units     <= 4'd0;
                            Tens      <= 4'd0;
                            Hundreds  <= 2'd0;
                            Zero      <= 1'b0;
                            Overflow  <= 1'b0;
                            Carry_out <= 1'b0;
`ifdef SIGNED_INPUT_EN
                            Negative  <= 1'b0;
`endif
                        end
                    end
                end
                SHIFT: begin
                    operand <= operand_next;
                    scratch <= scratch_next;
                    count   <= count + 3'd1;
                    if (last_iter) begin
                        Units     <= scratch_next[3:0];
                        Tens      <= scratch_next[7:4];
                        Hundreds  <= scratch_next[9:8];
                        Zero      <= (scratch_next == 10'd0);
                        Overflow  <= ov_cap;
                        Carry_out <= cy_cap;
                        done      <= 1'b1;
`ifdef SIGNED_INPUT_EN
                        Negative  <= neg_cap;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_binary_to_bcd_encoder.sv
// Directed bench for binary_to_bcd_encoder with an expected-result queue and arithmetic reference model.
module tb_binary_to_bcd_encoder;
    localparam int W = 14;

    logic       clock = 1'b0;
    logic       reset, start, Overflow_in, Carry_in;
    logic [7:0] Binary;
    logic       busy, done, Zero, Overflow, Carry_out, fsm_state;
    logic [3:0] Units, Tens;
    logic [1:0] Hundreds;
`ifdef SIGNED_INPUT_EN
    logic       Negative;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_result = '0;

    binary_to_bcd_encoder dut (
        .clock(clock), .reset(reset), .start(start), .Binary(Binary),
        .Overflow_in(Overflow_in), .Carry_in(Carry_in),
        .busy(busy), .done(done), .Units(Units), .Tens(Tens), .Hundreds(Hundreds),
        .Zero(Zero), .Overflow(Overflow), .Carry_out(Carry_out),
`ifdef SIGNED_INPUT_EN
        .Negative(Negative),
`endif
        .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    // Packing: {Units, Tens, Hundreds, Zero, Overflow, Carry_out, Negative}
    function automatic logic [W-1:0] model(input logic [7:0] b, input logic ov, input logic cy);
        logic [7:0] m;
        logic       neg;
        int         v;
        m   = b;
        neg = 1'b0;
`ifdef SIGNED_INPUT_EN
        neg = b[7];
        if (b[7]) m = ~b + 8'd1;
`endif
        v = int'(m);
        return {4'(v % 10), 4'((v / 10) % 10), 2'(v / 100), (v == 0), ov, cy, neg};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        logic neg;
        neg = 1'b0;
`ifdef SIGNED_INPUT_EN
        neg = Negative;
`endif
        return {Units, Tens, Hundreds, Zero, Overflow, Carry_out, neg};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input logic [7:0] b, input logic ov, input logic cy);
        Binary = b; Overflow_in = ov; Carry_in = cy; start = 1'b1;
        exp_q.push_back(model(b, ov, cy));
        @(negedge clock);
        start = 1'b0;
        Binary = 8'($urandom_range(0, 255));
        Overflow_in = 1'($urandom_range(0, 1));
        Carry_in = 1'($urandom_range(0, 1));
    endtask

    task automatic run_to_done(input string tag, input int lat);
        int cyc, busy_cnt;
        logic [W-1:0] e;
        cyc = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < lat + 8) begin
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            @(negedge clock);
            cyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busy_cycles"}, busy_cnt, lat);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        if (done === 1'b1) begin
            check({tag, "_busy_at_done"}, busy, 0);
            check({tag, "_result"}, obs_vec(), e);
            last_result = e;
            @(negedge clock);
            check({tag, "_done_pulse"}, done, 0);
        end
    endtask

    initial begin
        int n;
        int vals[4] = '{99, 100, 199, 200};

        reset = 1'b1; start = 1'b0; Binary = 8'd0; Overflow_in = 1'b0; Carry_in = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", obs_vec(), 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", fsm_state, 0);
        reset = 1'b0;
        @(negedge clock);

        reset = 1'b1; start = 1'b1; Binary = 8'd77;
        @(negedge clock);
        check("reset_beats_start", busy, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clock);

        start_conv(8'd255, 1'b0, 1'b1);
        check("state_shift", fsm_state, 1);
        run_to_done("max", 8);
`ifndef SIGNED_INPUT_EN
        check("max_direct", obs_vec(), {4'd5, 4'd5, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0});
`endif

        start_conv(8'd0, 1'b1, 1'b0);
        run_to_done("zero", 8);
        check("zero_direct", obs_vec(), {4'd0, 4'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0});

        for (int i = 0; i < 4; i++) begin
            start_conv(8'(vals[i]), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_to_done("boundary", 8);
        end
        for (int v = 0; v < 256; v++) begin
            start_conv(8'(v), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_to_done("all_values", 8);
        end

        start_conv(8'd37, 1'b0, 1'b0);
        @(negedge clock);
        check("hold_previous", obs_vec(), last_result);
        @(negedge clock);
        Binary = 8'd200; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        run_to_done("ignored_start", 5);
        check("ignored_start_value", obs_vec(), {4'd7, 4'd3, 2'd0, 3'b000, 1'b0});
        n = 0;
        repeat (12) begin
            @(negedge clock);
            if (done === 1'b1) n++;
        end
        check("single_done", n, 0);

        start_conv(8'd150, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_outputs", obs_vec(), 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        reset = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clock);
            if (done === 1'b1) n++;
        end
        check("abort_no_done", n, 0);
        start_conv(8'd42, 1'b0, 1'b0);
        run_to_done("after_reset", 8);
        check("after_reset_value", obs_vec(), {4'd2, 4'd4, 2'd0, 3'b000, 1'b0});

        Binary = 8'd63; Overflow_in = 1'b0; Carry_in = 1'b1; start = 1'b1;
        exp_q.push_back(model(8'd63, 1'b0, 1'b1));
        @(negedge clock);
        Binary = 8'd128; Overflow_in = 1'b1; Carry_in = 1'b0;
        exp_q.push_back(model(8'd128, 1'b1, 1'b0));
        run_to_done("b2b_first", 8);
        start = 1'b0;
        run_to_done("b2b_second", 8);
        check("b2b_queue_empty", exp_q.size(), 0);

`ifdef SIGNED_INPUT_EN
        start_conv(8'h80, 1'b0, 1'b0);
        run_to_done("neg128", 8);
        check("neg128_direct", obs_vec(), {4'd8, 4'd2, 2'd1, 3'b000, 1'b1});
        start_conv(8'hFF, 1'b0, 1'b0);
        run_to_done("neg1", 8);
        check("neg1_direct", obs_vec(), {4'd1, 4'd0, 2'd0, 3'b000, 1'b1});
        start_conv(8'd127, 1'b0, 1'b0);
        run_to_done("pos127", 8);
        check("pos127_direct", obs_vec(), {4'd7, 4'd2, 2'd1, 3'b000, 1'b0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
